// File: rtl/logic_pkg.sv
// Shared constants and types for the sequential cells of the digital-logic device library.
// Holds the modulus floor, direction encodings and the counter operation selector.
package logic_pkg;

    localparam int unsigned MOD_MIN  = 32'd2;
    localparam logic        DIR_DOWN = 1'b0;
    localparam logic        DIR_UP   = 1'b1;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_COUNT = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLR   = 2'd3
    } op_e;

endpackage

// File: rtl/logic_modstep.sv
// Combinational modulo-N step: next count value and wrap indication from (q, up).
// Kept standalone so a presettable divider can reuse the same step rule.
module logic_modstep
    import logic_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32'd4,
    parameter longint unsigned  MODULUS = 64'd16
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_max_ext;

    // Extra top bit keeps the terminal compare exact even when MODULUS == 2^WIDTH.
    assign w_q_ext   = {1'b0, i_q};
    assign w_max_ext = {1'b0, MAX_Q};

    // Step up or down, folding back at the modulus boundary.
    always_comb begin
        o_next = i_q;
        o_wrap = 1'b0;
        if (i_up == DIR_UP) begin
            if (w_q_ext == w_max_ext) begin
                o_next = '0;
                o_wrap = 1'b1;
            end else begin
                o_next = i_q + WIDTH'(1'b1);
                o_wrap = 1'b0;
            end
        end else begin
            if (w_q_ext == '0) begin
                o_next = MAX_Q;
                o_wrap = 1'b1;
            end else begin
                o_next = i_q - WIDTH'(1'b1);
                o_wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/logic_modcounter.sv
// Up/down modulo-N counter with synchronous clear, clamped parallel load,
// combinational terminal count and registered wrap / load-error pulses.
module logic_modcounter
    import logic_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32'd4,
    parameter longint unsigned  MODULUS = 64'd16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_load_err
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    if ((WIDTH < 32'd1) || (WIDTH > 32'd32)) begin : g_bad_width
        $error("logic_modcounter: WIDTH must be 1..32");
    end
    if ((MODULUS < 64'(MOD_MIN)) || (MODULUS > (64'd1 << WIDTH))) begin : g_bad_modulus
        $error("logic_modcounter: MODULUS must be 2..2^WIDTH");
    end

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_load_err;

    logic [WIDTH-1:0] w_step_q;
    logic             w_step_wrap;
    logic [WIDTH-1:0] w_load_q;
    logic             w_load_err;
    op_e              w_op;

    logic_modstep #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .i_q    (r_q),
        .i_up   (i_up),
        .o_next (w_step_q),
        .o_wrap (w_step_wrap)
    );

    // Operation priority: clear over load over count.
    always_comb begin
        w_op = OP_HOLD;
        if (i_clr) begin
            w_op = OP_CLR;
        end else if (i_load) begin
            w_op = OP_LOAD;
        end else if (i_en) begin
            w_op = OP_COUNT;
        end else begin
            w_op = OP_HOLD;
        end
    end

    // Out-of-range load values are clamped to the top count and flagged.
    always_comb begin
        w_load_q   = i_din;
        w_load_err = 1'b0;
        if ({1'b0, i_din} < MOD_W) begin
            w_load_q   = i_din;
            w_load_err = 1'b0;
        end else begin
            w_load_q   = MAX_Q;
            w_load_err = 1'b1;
        end
    end

    // Count state and one-cycle event flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            case (w_op)
                OP_CLR: begin
                    r_q        <= '0;
                    r_wrap     <= 1'b0;
                    r_load_err <= 1'b0;
                end
                OP_LOAD: begin
                    r_q        <= w_load_q;
                    r_wrap     <= 1'b0;
                    r_load_err <= w_load_err;
                end
                OP_COUNT: begin
                    r_q        <= w_step_q;
                    r_wrap     <= w_step_wrap;
                    r_load_err <= 1'b0;
                end
                default: begin
                    r_q        <= r_q;
                    r_wrap     <= 1'b0;
                    r_load_err <= 1'b0;
                end
            endcase
        end
    end

    assign o_q        = r_q;
    assign o_wrap     = r_wrap;
    assign o_load_err = r_load_err;
    assign o_tc       = (i_up == DIR_UP) ? (r_q == MAX_Q) : (r_q == '0);

endmodule

// File: tb/tb_logic_modcounter.sv
// Bench for logic_modcounter: a MOD-10 (4-bit) and a full-range MOD-8 (3-bit) instance
// driven in parallel and compared against an arithmetic reference model.
module tb_logic_modcounter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] din;
    logic [2:0] din3;

    logic [3:0] q10;
    logic       tc10;
    logic       wrap10;
    logic       lerr10;
    logic [2:0] q8;
    logic       tc8;
    logic       wrap8;
    logic       lerr8;

    int total;
    int bad;

    int m10_q;
    bit m10_w;
    bit m10_e;
    int m8_q;
    bit m8_w;
    bit m8_e;

    assign din3 = din[2:0];

    logic_modcounter #(.WIDTH(32'd4), .MODULUS(64'd10)) u_dut10 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_up       (up),
        .i_clr      (clr),
        .i_load     (load),
        .i_din      (din),
        .o_q        (q10),
        .o_tc       (tc10),
        .o_wrap     (wrap10),
        .o_load_err (lerr10)
    );

    logic_modcounter #(.WIDTH(32'd3), .MODULUS(64'd8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_up       (up),
        .i_clr      (clr),
        .i_load     (load),
        .i_din      (din3),
        .o_q        (q8),
        .o_tc       (tc8),
        .o_wrap     (wrap8),
        .o_load_err (lerr8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour of one counter for one rising edge, from the current inputs.
    task automatic model_edge(input int m, input int d, inout int q, inout bit w, inout bit e);
        if (clr) begin
            q = 0; w = 1'b0; e = 1'b0;
        end else if (load) begin
            if (d < m) begin
                q = d; e = 1'b0;
            end else begin
                q = m - 1; e = 1'b1;
            end
            w = 1'b0;
        end else if (en) begin
            if (up) begin
                w = (q == m - 1);
                q = (q + 1) % m;
            end else begin
                w = (q == 0);
                q = (q + m - 1) % m;
            end
            e = 1'b0;
        end else begin
            w = 1'b0; e = 1'b0;
        end
    endtask

    task automatic check_all();
        chk_eq("q10",    32'(q10),    32'(m10_q));
        chk_eq("wrap10", 32'(wrap10), 32'(m10_w));
        chk_eq("lerr10", 32'(lerr10), 32'(m10_e));
        chk_eq("tc10",   32'(tc10),   up ? 32'(m10_q == 9) : 32'(m10_q == 0));
        chk_eq("q8",     32'(q8),     32'(m8_q));
        chk_eq("wrap8",  32'(wrap8),  32'(m8_w));
        chk_eq("lerr8",  32'(lerr8),  32'(m8_e));
        chk_eq("tc8",    32'(tc8),    up ? 32'(m8_q == 7) : 32'(m8_q == 0));
    endtask

    task automatic step();
        model_edge(10, int'(din),  m10_q, m10_w, m10_e);
        model_edge(8,  int'(din3), m8_q,  m8_w,  m8_e);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_in(input bit c, input bit l, input bit e, input bit u, input int d);
        clr = c; load = l; en = e; up = u; din = 4'(d);
    endtask

    task automatic model_reset();
        m10_q = 0; m10_w = 1'b0; m10_e = 1'b0;
        m8_q  = 0; m8_w  = 1'b0; m8_e  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 0);
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Hold with en low after release.
        for (int i = 0; i < 3; i++) step();

        // Up count through the wrap from 0 (MOD-8 runs its full range).
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 12; i++) step();
        chk_eq("up_end_q10", 32'(q10), 32'd2);

        // Down wrap from 1.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) step();
        chk_eq("down_end_q10", 32'(q10), 32'd8);

        // Load clamp, then in-range load.
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 13);
        step();
        chk_eq("clamp_q10", 32'(q10), 32'd9);
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 5);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 0);
        step();

        // Priority: clear beats load and count; load beats count.
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 6);
        step();
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3);
        step();
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 3);
        step();
        chk_eq("load_over_en_q10", 32'(q10), 32'd3);

        // Asynchronous reset in mid-cycle at q=7, no clock edge involved.
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 6);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        en = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) step();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 15)));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
